// File: rtl/mips_pkg.sv
// Shared constants and types for the HI/LO multiply/divide sequencer.
package mips_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic HI_SEL = 1'b0;
   localparam logic LO_SEL = 1'b1;

   // Sliced down to the operand width where used.
   localparam logic [63:0] DIV0_LO = '1;

   typedef struct packed {
      logic div_sel;
      logic res_neg;
      logic rem_neg;
      logic div0;
   } op_info_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit facing request/response bundle for the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);

   logic             start;
   logic             mul0_div1_sel;
   logic             is_signed;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             hilo_rd;
   logic             hilo_we;
   logic             hi0_lo1_sel;
   logic [WIDTH-1:0] hilo_wdata;
   logic [WIDTH-1:0] hilo_rdata;
   logic             busy;
   logic             stall;
   logic             done;

   modport master (
      output start, mul0_div1_sel, is_signed, op_a, op_b,
      output hilo_rd, hilo_we, hi0_lo1_sel, hilo_wdata,
      input  hilo_rdata, busy, stall, done
   );

   modport slave (
      input  start, mul0_div1_sel, is_signed, op_a, op_b,
      input  hilo_rd, hilo_we, hi0_lo1_sel, hilo_wdata,
      output hilo_rdata, busy, stall, done
   );

endinterface

// File: rtl/muldiv_core.sv
// Stateless datapath: one shift-add / restoring shift-subtract step, plus final sign fix.
module muldiv_core
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_info_t           info,
   input  logic [WIDTH-1:0]   opnd,
   input  logic [WIDTH-1:0]   a_raw,
   input  logic [2*WIDTH-1:0] prod,
   output logic [2*WIDTH-1:0] prod_step,
   output logic [WIDTH-1:0]   hi_fix,
   output logic [WIDTH-1:0]   lo_fix
);

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_top;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
      // Divide keeps {remainder, dividend/quotient}; the top W+1 bits after a left shift.
      div_top  = prod[2*WIDTH-1:WIDTH-1];
      div_diff = div_top - {1'b0, opnd};

      if (info.div_sel) begin
         if (!div_diff[WIDTH]) begin
            prod_step = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
         end else begin
            prod_step = {div_top[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
         end
      end else begin
         prod_step = {mul_sum, prod[WIDTH-1:1]};
      end

      prod_neg = -prod;
      quo      = prod[WIDTH-1:0];
      rem      = prod[2*WIDTH-1:WIDTH];

      if (info.div_sel) begin
         lo_fix = info.div0 ? DIV0_LO[WIDTH-1:0] : (info.res_neg ? -quo : quo);
         hi_fix = info.div0 ? a_raw : (info.rem_neg ? -rem : rem);
      end else begin
         {hi_fix, lo_fix} = info.res_neg ? prod_neg : prod;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; WIDTH+1 cycles per op, stalls
// HI/LO accesses and new ops while busy.
module muldiv_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_sequencer_if.slave bus
);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   op_info_t           info_q, info_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               a_sign, b_sign;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_step;
   logic [WIDTH-1:0]   hi_fix, lo_fix;

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .info      (info_q),
      .opnd      (opnd_q),
      .a_raw     (a_raw_q),
      .prod      (prod_q),
      .prod_step (prod_step),
      .hi_fix    (hi_fix),
      .lo_fix    (lo_fix)
   );

   assign bus.busy       = (state_q != IDLE);
   assign bus.stall      = bus.busy & (bus.start | bus.hilo_rd | bus.hilo_we);
   assign bus.hilo_rdata = (bus.hi0_lo1_sel == HI_SEL) ? hi_q : lo_q;
   assign bus.done       = done_q;

   assign a_sign = bus.is_signed & bus.op_a[WIDTH-1];
   assign b_sign = bus.is_signed & bus.op_b[WIDTH-1];
   assign mag_a  = a_sign ? -bus.op_a : bus.op_a;
   assign mag_b  = b_sign ? -bus.op_b : bus.op_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opnd_d  = opnd_q;
      a_raw_d = a_raw_q;
      prod_d  = prod_q;
      info_d  = info_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.hilo_we) begin
               if (bus.hi0_lo1_sel == LO_SEL) lo_d = bus.hilo_wdata;
               else                           hi_d = bus.hilo_wdata;
            end
            if (bus.start) begin
               // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
               opnd_d         = bus.mul0_div1_sel ? mag_b : mag_a;
               prod_d         = {{WIDTH{1'b0}}, (bus.mul0_div1_sel ? mag_a : mag_b)};
               a_raw_d        = bus.op_a;
               info_d.div_sel = bus.mul0_div1_sel;
               info_d.res_neg = a_sign ^ b_sign;
               info_d.rem_neg = a_sign;
               info_d.div0    = (bus.op_b == '0);
               cnt_d          = '0;
               state_d        = CALC;
            end
         end
         CALC: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            hi_d    = hi_fix;
            lo_d    = lo_fix;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opnd_q  <= '0;
         a_raw_q <= '0;
         prod_q  <= '0;
         info_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         a_raw_q <= a_raw_d;
         prod_q  <= prod_d;
         info_q  <= info_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, stalls, HI/LO moves and reset abort.
module tb_muldiv_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      bus.hi0_lo1_sel = 1'b0;
      #1 hi = bus.hilo_rdata;
      bus.hi0_lo1_sel = 1'b1;
      #1 lo = bus.hilo_rdata;
   endtask

   // Issue one op, then watch every cycle until done (bounded). lat = cycles from the
   // start edge to the cycle done is seen; err counts busy/stall deviations on the way.
   task automatic run_op(input logic md, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int rd_at, input int st_at,
                         output int lat, output int err);
      lat = -1;
      err = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.mul0_div1_sel = md; bus.is_signed = sgn;
      bus.op_a = a; bus.op_b = b;
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         logic exp_busy;
         exp_busy = (n <= 32);
         bus.hilo_rd = (rd_at >= 0) && (n >= rd_at);
         bus.hi0_lo1_sel = 1'b1;
         if (n == st_at) begin
            bus.start = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd5;
         end else begin
            bus.start = 1'b0;
         end
         #1;
         if (bus.busy !== exp_busy) err++;
         if ((bus.hilo_rd || bus.start) && (bus.stall !== exp_busy)) err++;
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.hilo_rd = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] hi, lo;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      read_hilo(hi, lo);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
      vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
      vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
      rst = 1'b0;
   endtask

   task automatic test_multu;
      int lat, err;
      logic [31:0] hi, lo;
      run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, 1, -1, lat, err);
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL multu_latency got %0d want 33", lat); end
      vectors++; if (err !== 0) begin miscompares++; $display("FAIL multu_busy_stall got %0d errors want 0", err); end
      read_hilo(hi, lo);
      vectors++; if (hi !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_hi got %h want 00000001", hi); end
      vectors++; if (lo !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_lo got %h want fffffffe", lo); end
      @(negedge clk); #1;
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
   endtask

   task automatic test_mult_mflo;
      int lat, err;
      logic [31:0] hi, lo;
      run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 5, -1, lat, err);
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mult_latency got %0d want 33", lat); end
      vectors++; if (err !== 0) begin miscompares++; $display("FAIL mflo_stall got %0d errors want 0", err); end
      read_hilo(hi, lo);
      vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      vectors++; if (lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mflo_lo got %h want ffffffeb", lo); end
   endtask

   task automatic test_div;
      int lat, err;
      logic [31:0] hi, lo;
      run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, lat, err);
      vectors++; if (lat !== 33 || err !== 0) begin miscompares++; $display("FAIL div_timing got lat %0d err %0d want 33/0", lat, err); end
      read_hilo(hi, lo);
      vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_quo got %h want fffffffd", lo); end
      vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_rem got %h want ffffffff", hi); end
      run_op(1'b1, 1'b0, 32'd100, 32'd7, -1, -1, lat, err);
      vectors++; if (lat !== 33 || err !== 0) begin miscompares++; $display("FAIL divu_timing got lat %0d err %0d want 33/0", lat, err); end
      read_hilo(hi, lo);
      vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_quo got %0d want 14", lo); end
      vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_rem got %0d want 2", hi); end
   endtask

   task automatic test_div_corners;
      int lat, err;
      logic [31:0] hi, lo;
      run_op(1'b1, 1'b0, 32'h0000_1234, 32'h0, -1, -1, lat, err);
      vectors++; if (lat !== 33 || err !== 0) begin miscompares++; $display("FAIL div0_timing got lat %0d err %0d want 33/0", lat, err); end
      read_hilo(hi, lo);
      vectors++; if (hi !== 32'h0000_1234) begin miscompares++; $display("FAIL div0_hi got %h want 00001234", hi); end
      vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo got %h want ffffffff", lo); end
      run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, lat, err);
      vectors++; if (lat !== 33 || err !== 0) begin miscompares++; $display("FAIL ovf_timing got lat %0d err %0d want 33/0", lat, err); end
      read_hilo(hi, lo);
      vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_lo got %h want 80000000", lo); end
      vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL ovf_hi got %h want 00000000", hi); end
   endtask

   task automatic test_hilo_move;
      @(negedge clk);
      bus.hilo_we = 1'b1; bus.hi0_lo1_sel = 1'b0; bus.hilo_wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      bus.hilo_we = 1'b0; bus.hilo_rd = 1'b1; bus.hi0_lo1_sel = 1'b0;
      #1;
      vectors++; if (bus.hilo_rdata !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL mfhi_data got %h want a5a5a5a5", bus.hilo_rdata); end
      vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL mfhi_idle_stall got %b want 0", bus.stall); end
      bus.hi0_lo1_sel = 1'b1;
      #1;
      vectors++; if (bus.hilo_rdata !== 32'h8000_0000) begin miscompares++; $display("FAIL mthi_lo_untouched got %h want 80000000", bus.hilo_rdata); end
      bus.hilo_rd = 1'b0;
   endtask

   task automatic test_start_while_busy;
      int lat, err;
      logic [31:0] hi, lo;
      run_op(1'b0, 1'b1, 32'd6, 32'hFFFF_FFFC, -1, 10, lat, err);
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL busy_start_latency got %0d want 33", lat); end
      vectors++; if (err !== 0) begin miscompares++; $display("FAIL busy_start_stall got %0d errors want 0", err); end
      read_hilo(hi, lo);
      vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL busy_start_hi got %h want ffffffff", hi); end
      vectors++; if (lo !== 32'hFFFF_FFE8) begin miscompares++; $display("FAIL busy_start_lo got %h want ffffffe8", lo); end
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] hi, lo;
      int done_seen;
      @(negedge clk);
      bus.start = 1'b1; bus.mul0_div1_sel = 1'b1; bus.is_signed = 1'b1;
      bus.op_a = 32'd100; bus.op_b = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      read_hilo(hi, lo);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", bus.busy); end
      vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL abort_hi got %h want 0", hi); end
      vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL abort_lo got %h want 0", lo); end
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (bus.done === 1'b1) done_seen++;
      end
      vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
   endtask

   initial begin
      bus.start = 1'b0; bus.mul0_div1_sel = 1'b0; bus.is_signed = 1'b0;
      bus.op_a = '0; bus.op_b = '0; bus.hilo_rd = 1'b0; bus.hilo_we = 1'b0;
      bus.hi0_lo1_sel = 1'b0; bus.hilo_wdata = '0;
      test_reset();
      test_multu();
      test_mult_mflo();
      test_div();
      test_div_corners();
      test_hilo_move();
      test_start_while_busy();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for MIPS32 MULT/MULTU/DIV/DIVU, owning the HI/LO register pair.
- Sits in EX beside the ALU, driven by the control unit's muldiv_op, mul0_div1_sel, hilo_mov_op and hi0_lo1_sel.
- Runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Stalls the pipeline when an MFHI/MFLO/MTHI/MTLO or a new mul/div arrives while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  muldiv_op qualified by a valid EX instruction.
- mul0_div1_sel  in  1  0 = multiply, 1 = divide.
- is_signed  in  1  1 = MULT/DIV, 0 = MULTU/DIVU.
- op_a  in  WIDTH  rs value (multiplicand / dividend).
- op_b  in  WIDTH  rt value (multiplier / divisor).
- hilo_rd  in  1  MFHI/MFLO request (hilo_mov_op).
- hilo_we  in  1  MTHI/MTLO request.
- hi0_lo1_sel  in  1  selects HI (0) or LO (1) for read and write.
- hilo_wdata  in  WIDTH  MTHI/MTLO data.
- hilo_rdata  out  WIDTH  combinational HI or LO per hi0_lo1_sel.
- busy  out  1  operation in progress.
- stall  out  1  combinational pipeline stall request.
- done  out  1  one-cycle pulse on the cycle after HI/LO update.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0. Reset asserted mid-operation aborts it; no HI/LO write occurs.
- States: IDLE, CALC, FIX.
- IDLE, edge with start=1:
  - Latch |op_a| and |op_b| (absolute values when is_signed, raw otherwise).
  - Latch operation type, result sign (a_sign XOR b_sign), remainder sign (a_sign), and divide-by-zero flag (op_b==0).
  - Clear accumulator and counter; go to CALC.
- CALC:
  - One iteration per edge. Multiply: conditional add + right shift of the 2*WIDTH product. Divide: restoring shift-subtract, 1 quotient bit per edge.
  - After WIDTH iterations (counter==WIDTH-1 on that edge), go to FIX.
- FIX, one edge:
  - Apply sign fix (two's-complement negate of the product; or of quotient/remainder per latched signs).
  - Multiply: HI=product[2W-1:W], LO=product[W-1:0].
  - Divide: LO=quotient, HI=remainder.
  - Go to IDLE; done=1 for the next cycle.
- Latency: start sampled at edge 0 → HI/LO visible after edge WIDTH+1 (33 cycles for WIDTH=32).
- busy=1 from after edge 0 through the FIX edge inclusive.
- stall = busy & (start | hilo_rd | hilo_we). Stalled requests have no effect and must be held by the pipeline until stall drops.
- Divide by zero, regardless of signedness: full latency, HI=op_a as latched (original signed value), LO={WIDTH{1'b1}}.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0. This falls out of the magnitude algorithm plus the sign fix.
- hilo_we in IDLE: writes the selected register at that edge.
- hilo_rd is always combinational. When idle it returns current HI/LO.
- start together with hilo_rd in IDLE: the read returns the pre-operation value; the operation starts.
- start together with hilo_we in IDLE: the write is performed and the operation starts. The operation result later overwrites HI/LO.
- start while busy: ignored (stall asserted); no re-latch of operands.
- hilo_rdata during busy: returns old HI/LO. Its value is don't-care to the pipeline because stall is asserted.

Decomposition:
- Shared package, mips_pkg:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - HI_SEL=0 and LO_SEL=1 constants.
  - DIV0_LO constant (all ones).
- One natural sub-module, muldiv_core: the per-iteration datapath (shift-add / shift-subtract step plus sign fix), with no state of its own.
- muldiv_sequencer keeps the FSM, counter, operand/accumulator registers, HI/LO and stall logic.

Test Plan:
- MULTU 0xFFFFFFFF × 0x2 → stall during busy, done at cycle 33; HI=0x00000001, LO=0xFFFFFFFE.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MFLO issued at cycle 5: stall=1 until done, then rdata=0xFFFFFFEB.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 → LO=14, HI=2.
- DIVU 0x1234 / 0 → after 33 cycles, HI=0x00001234, LO=0xFFFFFFFF. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5 then MFHI in IDLE → rdata=0xA5A5A5A5, stall=0. A second start at cycle 10 of an active MULT → ignored, stall=1, first result intact.
- rst asserted at cycle 15 of a DIV → next cycle busy=0, HI=LO=0, and no done pulse follows.
